vga_brick_field_renderer: RTL and testbench

//  Parametrised VGA timing + Breakout scene renderer: sync/counters, ROWS x COLS brick grid, paddle.

---
 rtl/vga_brick_pkg.sv | 27 ++
 rtl/vga_timing_gen.sv | 81 ++++++++
 rtl/vga_brick_field_renderer.sv | 218 +++++++++++++++++++++
 tb/tb_vga_brick_field_renderer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_brick_pkg.sv
// Shared timing defaults, colour codes and helpers for the VGA brick-field renderer.
// Geometry defaults live with the top-level parameters.
package vga_brick_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam logic [2:0] C_BG     = 3'b000;
    localparam logic [2:0] C_PADDLE = 3'b001;
    localparam logic [2:0] C_ROW0   = 3'b010;
    localparam logic [2:0] C_ROWN   = 3'b110;

    // Index width for an N-entry brick table, never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus registered syncs and frame pulse; the registered outputs
// lag the counter value they describe by exactly one clock.
module vga_timing_gen
    import vga_brick_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic [9:0] o_h_nxt,
    output logic [9:0] o_v_nxt,
    output logic       o_line_adv,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_h;
    logic [9:0] r_v;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_start;
    logic [9:0] w_h_nxt;
    logic [9:0] w_v_nxt;
    logic       w_h_wrap;

    always_comb begin
        w_h_wrap = (r_h == H_LAST);
        w_h_nxt  = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_nxt  = r_v;
        if (w_h_wrap) begin
            w_v_nxt = (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= !((r_h >= HS_START) && (r_h < HS_END));
            r_vsync       <= !((r_v >= VS_START) && (r_v < VS_END));
            r_frame_start <= (r_h == 10'd0) && (r_v == 10'd0);
        end
    end

    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_h_nxt       = w_h_nxt;
    assign o_v_nxt       = w_v_nxt;
    assign o_line_adv    = w_h_wrap;
    assign o_active      = (r_h < H_ACT) && (r_v < V_ACT);
    assign o_hsync       = r_hsync;
    assign o_vsync       = r_vsync;
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_brick_field_renderer.sv
// Breakout scene renderer: brick grid with live/display masks, paddle overlay,
// hit/restore bookkeeping and a registered 3-bit colour output.
module vga_brick_field_renderer
    import vga_brick_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int ORIGIN_X = 40,
    parameter int ORIGIN_Y = 40,
    parameter int BRICK_W  = 80,
    parameter int BRICK_H  = 30,
    parameter int PITCH_X  = 120,
    parameter int PITCH_Y  = 70,
    parameter int PADDLE_Y = 440,
    parameter int PADDLE_H = 10,
    parameter int PADDLE_W = 100,
    localparam int N  = ROWS * COLS,
    localparam int IW = idx_width(N)
) (
    input  logic          CLK_25MH,
    input  logic          reset,
    input  logic [9:0]    paddle_pos,
    input  logic          hit_valid,
    input  logic [IW-1:0] hit_index,
    input  logic          restore,
    output logic [2:0]    RGB,
    output logic          hsync,
    output logic          vsync,
    output logic [9:0]    hor_count,
    output logic [9:0]    ver_count,
    output logic          frame_start,
    output logic [6:0]    bricks_left,
    output logic          all_clear
);

    localparam logic [9:0]   OX        = 10'(ORIGIN_X);
    localparam logic [9:0]   OY        = 10'(ORIGIN_Y);
    localparam logic [9:0]   BW        = 10'(BRICK_W);
    localparam logic [9:0]   BH        = 10'(BRICK_H);
    localparam logic [9:0]   PX_LAST   = 10'(PITCH_X - 1);
    localparam logic [9:0]   PY_LAST   = 10'(PITCH_Y - 1);
    localparam logic [6:0]   LAST_COL  = 7'(COLS - 1);
    localparam logic [6:0]   LAST_ROW  = 7'(ROWS - 1);
    localparam logic [6:0]   COLS_L    = 7'(COLS);
    localparam logic [6:0]   N_L       = 7'(N);
    localparam logic [9:0]   PY_TOP    = 10'(PADDLE_Y);
    localparam logic [9:0]   PY_END    = 10'(PADDLE_Y + PADDLE_H);
    localparam logic [10:0]  PW        = 11'(PADDLE_W);
    localparam logic [N-1:0] MASK_FULL = '1;
    localparam logic [N-1:0] ONE_N     = N'(1);

    logic [9:0]   w_h;
    logic [9:0]   w_v;
    logic [9:0]   w_h_nxt;
    logic [9:0]   w_v_nxt;
    logic         w_line_adv;
    logic         w_active;

    logic         r_col_on;
    logic [6:0]   r_col;
    logic [9:0]   r_xoff;
    logic         r_row_on;
    logic [6:0]   r_row;
    logic [6:0]   r_row_base;
    logic [9:0]   r_yoff;

    logic [N-1:0] r_live;
    logic [N-1:0] r_disp;
    logic [6:0]   r_left;
    logic         r_all_clear;
    logic [2:0]   r_rgb;

    logic [N-1:0] w_hit_oh;
    logic         w_hit_ok;
    logic [N-1:0] w_live_nxt;
    logic [6:0]   w_left_nxt;
    logic [6:0]   w_idx;
    logic         w_in_brick;
    logic [10:0]  w_pad_end;
    logic         w_in_pad;
    logic [2:0]   w_colour;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .i_clk         (CLK_25MH),
        .i_rst         (reset),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_h_nxt       (w_h_nxt),
        .o_v_nxt       (w_v_nxt),
        .o_line_adv    (w_line_adv),
        .o_active      (w_active),
        .o_hsync       (hsync),
        .o_vsync       (vsync),
        .o_frame_start (frame_start)
    );

    // Trackers describe the current (h,v); they step alongside the counters so
    // the brick column/row and offset within the pitch never need a divider.
    always_ff @(posedge CLK_25MH or posedge reset) begin
        if (reset) begin
            r_col_on   <= (OX == 10'd0);
            r_col      <= 7'd0;
            r_xoff     <= 10'd0;
            r_row_on   <= (OY == 10'd0);
            r_row      <= 7'd0;
            r_row_base <= 7'd0;
            r_yoff     <= 10'd0;
        end else begin
            if (w_h_nxt == OX) begin
                r_col_on <= 1'b1;
                r_col    <= 7'd0;
                r_xoff   <= 10'd0;
            end else if (w_line_adv) begin
                r_col_on <= 1'b0;
            end else if (r_col_on) begin
                if (r_xoff == PX_LAST) begin
                    r_xoff <= 10'd0;
                    if (r_col == LAST_COL) r_col_on <= 1'b0;
                    else                   r_col    <= r_col + 7'd1;
                end else begin
                    r_xoff <= r_xoff + 10'd1;
                end
            end

            if (w_line_adv) begin
                if (w_v_nxt == OY) begin
                    r_row_on   <= 1'b1;
                    r_row      <= 7'd0;
                    r_row_base <= 7'd0;
                    r_yoff     <= 10'd0;
                end else if (w_v_nxt == 10'd0) begin
                    r_row_on <= 1'b0;
                end else if (r_row_on) begin
                    if (r_yoff == PY_LAST) begin
                        r_yoff <= 10'd0;
                        if (r_row == LAST_ROW) begin
                            r_row_on <= 1'b0;
                        end else begin
                            r_row      <= r_row + 7'd1;
                            r_row_base <= r_row_base + COLS_L;
                        end
                    end else begin
                        r_yoff <= r_yoff + 10'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_hit_oh   = ONE_N << hit_index;
        w_hit_ok   = hit_valid && (7'(hit_index) < N_L) && (|(r_live & w_hit_oh));
        w_live_nxt = r_live;
        w_left_nxt = r_left;
        if (restore) begin
            w_live_nxt = MASK_FULL;
            w_left_nxt = N_L;
        end else if (w_hit_ok) begin
            w_live_nxt = r_live & ~w_hit_oh;
            w_left_nxt = r_left - 7'd1;
        end
    end

    always_comb begin
        w_idx      = r_row_base + r_col;
        w_in_brick = r_col_on && r_row_on && (r_xoff < BW) && (r_yoff < BH)
                     && (|(r_disp & (ONE_N << w_idx)));
        w_pad_end  = {1'b0, paddle_pos} + PW;
        w_in_pad   = (w_v >= PY_TOP) && (w_v < PY_END)
                     && (w_h >= paddle_pos) && ({1'b0, w_h} < w_pad_end);
        w_colour   = C_BG;
        if (w_active) begin
            if (w_in_pad)        w_colour = C_PADDLE;
            else if (w_in_brick) w_colour = (r_row == 7'd0) ? C_ROW0 : C_ROWN;
        end
    end

    // The display mask only moves at the top-left pixel so a frame never tears.
    always_ff @(posedge CLK_25MH or posedge reset) begin
        if (reset) begin
            r_live      <= MASK_FULL;
            r_disp      <= MASK_FULL;
            r_left      <= N_L;
            r_all_clear <= 1'b0;
            r_rgb       <= C_BG;
        end else begin
            r_live      <= w_live_nxt;
            r_left      <= w_left_nxt;
            r_all_clear <= (w_left_nxt == 7'd0);
            r_rgb       <= w_colour;
            if ((w_h == 10'd0) && (w_v == 10'd0)) r_disp <= r_live;
        end
    end

    assign hor_count   = w_h;
    assign ver_count   = w_v;
    assign RGB         = r_rgb;
    assign bricks_left = r_left;
    assign all_clear   = r_all_clear;

endmodule

// File: tb/tb_vga_brick_field_renderer.sv
// Directed bench for the brick-field renderer on a shrunken raster (120x26) so
// several whole frames fit in a short run; geometry is scaled to match.
module tb_vga_brick_field_renderer;

    localparam int FRAME = 120 * 26;
    localparam int LIMIT = 2 * FRAME + 10;

    logic       CLK_25MH = 1'b0;
    logic       reset;
    logic [9:0] paddle_pos;
    logic       hit_valid;
    logic [4:0] hit_index;
    logic       restore;
    logic [2:0] RGB;
    logic       hsync;
    logic       vsync;
    logic [9:0] hor_count;
    logic [9:0] ver_count;
    logic       frame_start;
    logic [6:0] bricks_left;
    logic       all_clear;

    int errors = 0;
    int checks = 0;

    always #20 CLK_25MH = ~CLK_25MH;

    vga_brick_field_renderer #(
        .H_ACTIVE (100), .H_FP (4), .H_SYNC (8), .H_BP (8),
        .V_ACTIVE (20),  .V_FP (2), .V_SYNC (2), .V_BP (2),
        .ROWS (5), .COLS (5),
        .ORIGIN_X (4), .ORIGIN_Y (2),
        .BRICK_W (12), .BRICK_H (2),
        .PITCH_X (20), .PITCH_Y (3),
        .PADDLE_Y (15), .PADDLE_H (2), .PADDLE_W (20)
    ) dut (
        .CLK_25MH    (CLK_25MH),
        .reset       (reset),
        .paddle_pos  (paddle_pos),
        .hit_valid   (hit_valid),
        .hit_index   (hit_index),
        .restore     (restore),
        .RGB         (RGB),
        .hsync       (hsync),
        .vsync       (vsync),
        .hor_count   (hor_count),
        .ver_count   (ver_count),
        .frame_start (frame_start),
        .bricks_left (bricks_left),
        .all_clear   (all_clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_25MH);
        #1;
    endtask

    task automatic goto(input int x, input int y);
        int n = 0;
        while (!(hor_count == 10'(x) && ver_count == 10'(y)) && n < LIMIT) begin
            tick();
            n++;
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $error("FAIL goto_timeout: at (%0d,%0d) wanted (%0d,%0d)", hor_count, ver_count, x, y);
        end
    endtask

    // Colour registered on the edge where the counters show (x,y).
    task automatic pix(input string tag, input int x, input int y, input logic [2:0] exp);
        goto(x, y);
        tick();
        check(tag, RGB, exp);
    endtask

    task automatic hit(input logic [4:0] idx, input logic rs);
        hit_valid = 1'b1;
        hit_index = idx;
        restore   = rs;
        tick();
        hit_valid = 1'b0;
        restore   = 1'b0;
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        paddle_pos = 10'd0;
        hit_valid  = 1'b0;
        hit_index  = 5'd0;
        restore    = 1'b0;
        repeat (3) tick();

        check("rst_h", hor_count, 0);
        check("rst_v", ver_count, 0);
        check("rst_rgb", RGB, 0);
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_fs", frame_start, 0);
        check("rst_left", bricks_left, 25);
        check("rst_clear", all_clear, 0);

        reset = 1'b0;
        tick();
        check("rel_fs", frame_start, 1);
        check("rel_h", hor_count, 1);

        // Mid-frame reset while both syncs are low.
        goto(106, 22);
        check("pre_hsync", hsync, 0);
        check("pre_vsync", vsync, 0);
        reset = 1'b1;
        tick();
        check("mid_rst_h", hor_count, 0);
        check("mid_rst_v", ver_count, 0);
        check("mid_rst_hsync", hsync, 1);
        check("mid_rst_vsync", vsync, 1);
        check("mid_rst_rgb", RGB, 0);
        check("mid_rst_fs", frame_start, 0);
        reset = 1'b0;
        tick();
        check("restart_fs", frame_start, 1);
        check("restart_h", hor_count, 1);
        check("restart_v", ver_count, 0);

        // Sync timing.
        n = 0;
        while (hsync !== 1'b0 && n < 200) begin tick(); n++; end
        check("hs_start_h", hor_count, 105);
        check("hs_start_v", ver_count, 0);
        n = 0;
        while (hsync === 1'b0 && n < 200) begin tick(); n++; end
        check("hs_width", n, 8);

        n = 0;
        while (vsync !== 1'b0 && n < LIMIT) begin tick(); n++; end
        check("vs_start_h", hor_count, 1);
        check("vs_start_v", ver_count, 22);
        n = 0;
        while (vsync === 1'b0 && n < LIMIT) begin tick(); n++; end
        check("vs_width", n, 240);

        n = 0;
        while (frame_start !== 1'b1 && n < LIMIT) begin tick(); n++; end
        check("fs_pos_h", hor_count, 1);
        check("fs_pos_v", ver_count, 0);
        n = 0;
        do begin tick(); n++; end while (frame_start !== 1'b1 && n < LIMIT);
        check("fs_period", n, FRAME);

        // Brick geometry, all within one frame.
        pix("px_3_2", 3, 2, 3'b000);
        pix("px_4_2", 4, 2, 3'b010);
        pix("px_15_2", 15, 2, 3'b010);
        pix("px_16_2", 16, 2, 3'b000);
        pix("px_24_3", 24, 3, 3'b010);
        pix("px_4_4", 4, 4, 3'b000);
        pix("px_4_5", 4, 5, 3'b110);
        pix("px_4_7", 4, 7, 3'b000);
        pix("px_95_14", 95, 14, 3'b110);
        pix("px_96_14", 96, 14, 3'b000);

        // Hit before row 0 is drawn: display mask holds until next frame.
        goto(0, 1);
        hit(5'd0, 1'b0);
        check("hit0_left", bricks_left, 24);
        pix("hit0_same_frame", 4, 2, 3'b010);
        pix("hit0_neighbour", 24, 2, 3'b010);
        pix("hit0_next_frame", 4, 2, 3'b000);
        pix("hit0_neighbour2", 24, 2, 3'b010);

        hit(5'd0, 1'b0);
        check("rehit0_left", bricks_left, 24);
        hit(5'd25, 1'b0);
        check("hit25_left", bricks_left, 24);
        hit(5'd31, 1'b0);
        check("hit31_left", bricks_left, 24);
        hit(5'd3, 1'b1);
        check("restore_wins_left", bricks_left, 25);
        check("restore_clear", all_clear, 0);
        pix("restored_b0", 4, 2, 3'b010);
        pix("restored_b3", 64, 2, 3'b010);

        for (int i = 0; i < 25; i++) begin
            hit(5'(i), 1'b0);
            if (i == 23) begin
                check("one_left", bricks_left, 1);
                check("one_left_clear", all_clear, 0);
            end
        end
        check("cleared_left", bricks_left, 0);
        check("cleared_flag", all_clear, 1);
        pix("cleared_b0", 4, 2, 3'b000);
        pix("cleared_b24", 84, 14, 3'b000);
        restore = 1'b1;
        tick();
        restore = 1'b0;
        check("refill_left", bricks_left, 25);
        check("refill_clear", all_clear, 0);

        // Paddle overlapping the last brick row and clipped at the active edge.
        paddle_pos = 10'd84;
        pix("pad_brick_above", 84, 14, 3'b110);
        pix("pad_left_gap", 83, 15, 3'b000);
        pix("pad_over_brick", 84, 15, 3'b001);
        pix("pad_right", 99, 16, 3'b001);
        pix("pad_clip", 100, 16, 3'b000);
        pix("pad_below", 84, 17, 3'b000);

        paddle_pos = 10'd1020;
        pix("nowrap_brick", 5, 15, 3'b110);
        pix("nowrap_bg", 5, 16, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
